// File: rtl/led_matrix_row_driver_if.sv
// Avalon-MM slave bus bundle for the LED matrix row driver.
interface led_matrix_row_driver_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_matrix_row_driver.sv
// HUB75 row-scan engine: software fills a COLS-deep line buffer, then a start
// command shifts the row out on sclk, pulses lat, drives the row address and
// enables the panel for a programmable number of cycles.
module led_matrix_row_driver #(
    parameter int COLS     = 32,
    parameter int ROW_BITS = 4,
    parameter int CLK_DIV  = 2,
    parameter int ONTIME_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    led_matrix_row_driver_if.slave  bus,
    output logic [5:0]              rgb,
    output logic                    sclk,
    output logic                    lat,
    output logic                    oe_n,
    output logic [ROW_BITS-1:0]     row_addr
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PH_W  = $clog2(2 * CLK_DIV);

    // Phase counter limits: one column spans 2*CLK_DIV cycles, lat spans CLK_DIV.
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  LAT_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_ONTIME = 2'd2;
    localparam logic [1:0] ADDR_DATA   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [5:0]            r_buf [COLS];
    logic [COL_W-1:0]      r_wr_ptr;
    logic [COL_W-1:0]      r_col;
    logic [PH_W-1:0]       r_ph;
    logic [ONTIME_W-1:0]   r_on;
    logic [ONTIME_W-1:0]   r_ontime;
    logic [ROW_BITS-1:0]   r_row;
    logic [ROW_BITS-1:0]   r_row_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_wr;
    logic                  w_buf_we;
    logic                  w_done_set;
    logic                  w_state_chg;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_buf_we    = w_wr && (bus.address == ADDR_DATA) && !r_busy;
    assign w_state_chg = (w_next != r_state);
    assign w_done_set  = (r_state != S_IDLE) && (w_next == S_IDLE);
    assign row_addr    = r_row_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an accepted start spends one cycle in IDLE with busy set
    // before SHIFT begins, which gives the 1-cycle lead in the start-to-done latency.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_busy) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if ((r_ph == PH_LAST) && (r_col == COL_LAST)) w_next = S_LATCH;
            end
            S_LATCH: begin
                if (r_ph == LAT_LAST) w_next = (r_ontime == '0) ? S_IDLE : S_DISPLAY;
            end
            S_DISPLAY: begin
                if (r_on == (r_ontime - 1'b1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Panel pin decode from the current state and phase.
    always_comb begin
        rgb  = '0;
        sclk = 1'b0;
        lat  = 1'b0;
        oe_n = 1'b1;
        unique case (r_state)
            S_SHIFT: begin
                rgb  = r_buf[r_col];
                sclk = (r_ph >= PH_HALF);
            end
            S_LATCH:   lat  = 1'b1;
            S_DISPLAY: oe_n = 1'b0;
            default: ;
        endcase
    end

    // Column, phase and on-time counters; all restart at every state change.
    always_ff @(posedge clk) begin
        if (reset || w_state_chg) begin
            r_ph  <= '0;
            r_col <= '0;
            r_on  <= '0;
        end else begin
            unique case (r_state)
                S_SHIFT: begin
                    if (r_ph == PH_LAST) begin
                        r_ph  <= '0;
                        r_col <= r_col + 1'b1;
                    end else begin
                        r_ph <= r_ph + 1'b1;
                    end
                end
                S_LATCH:   r_ph <= r_ph + 1'b1;
                S_DISPLAY: r_on <= r_on + 1'b1;
                default: ;
            endcase
        end
    end

    // Register file, status flags and write pointer; done-set is last so it wins
    // over a coincident write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wr_ptr <= '0;
            r_row    <= '0;
            r_ontime <= '0;
        end else begin
            if (w_wr && (bus.address == ADDR_STATUS)) begin
                if (bus.writedata[1]) r_done <= 1'b0;
                if (bus.writedata[2]) r_err  <= 1'b0;
            end
            if (w_wr && (bus.address != ADDR_STATUS)) begin
                if (r_busy) begin
                    r_err <= 1'b1;
                end else begin
                    unique case (bus.address)
                        ADDR_CTRL: begin
                            r_row <= bus.writedata[ROW_BITS-1:0];
                            if (bus.writedata[8] || bus.writedata[9]) r_wr_ptr <= '0;
                            if (bus.writedata[8]) r_busy <= 1'b1;
                        end
                        ADDR_ONTIME: r_ontime <= bus.writedata[ONTIME_W-1:0];
                        ADDR_DATA:   r_wr_ptr <= r_wr_ptr + 1'b1;
                        default: ;
                    endcase
                end
            end
            if (w_done_set) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Line buffer storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && w_buf_we) begin
            r_buf[r_wr_ptr] <= bus.writedata[5:0];
        end
    end

    // Row address is captured as the row enters LATCH and held until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_addr <= '0;
        end else if ((r_state == S_SHIFT) && (w_next == S_LATCH)) begin
            r_row_addr <= r_row;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            ADDR_CTRL:   bus.readdata[ROW_BITS-1:0] = r_row;
            ADDR_STATUS: bus.readdata[2:0]          = {r_err, r_done, r_busy};
            ADDR_ONTIME: bus.readdata[ONTIME_W-1:0] = r_ontime;
            default: ;
        endcase
    end

endmodule
